cmem_loader: RTL and testbench
==============================

Name: cmem_loader

Overview:
Master end of the cmem coefficient serial chain. It accepts parallel coefficient words over a valid/ready handshake and shifts them MSB-first into the chain through sde/sd. It can also read the whole chain back non-destructively by recirculating the chain's serial output into its input, and returns the words over a valid/ready handshake. It sits between the host/config logic and cmem. It is the only block that drives the cmem scan inputs.

Parameters:
CMEMSIZE, 4, number of coefficient words in the chain; must match the myfilter_pkg value used by cmem.
DATABITS, 8, bits per coefficient word; must match the myfilter_pkg value.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
in_valid  in  1  host word valid.
in_ready  out  1  loader can accept a word.
in_data  in  DATABITS  coefficient word.
rd_start  in  1  single-cycle request for a full-chain readback.
rd_valid  out  1  readback word valid.
rd_ready  in  1  host accepts the readback word.
rd_data  out  DATABITS  readback word.
rd_addr  out  $clog2(CMEMSIZE)  cmem address of rd_data.
load_done  out  1  one-cycle pulse after the CMEMSIZE-th loaded word.
rd_done  out  1  one-cycle pulse after the last readback word is accepted.
busy  out  1  state != IDLE.
sde_out  out  1  to cmem sde_in.
sd_out  out  1  to cmem sd_in.
sd_in  in  1  from cmem sd_out (chain MSB, registered in cmem).

Behaviour:
- Reset: state IDLE; word counter wcnt=0; bit counter=0; shift registers=0. All outputs 0 except in_ready=1. Reset applies at any time, including mid-shift; the partial chain contents are then undefined at loader level.
- States: IDLE, LOAD_SHIFT, RD_SHIFT, RD_HOLD.
- IDLE: in_ready=1, sde_out=0.
  - in_valid=1: capture in_data and go to LOAD_SHIFT. A load has priority over a simultaneous rd_start.
  - rd_start=1 with in_valid=0 and wcnt==0: go to RD_SHIFT.
  - rd_start while wcnt!=0 (partial load in progress): ignored.
- LOAD_SHIFT: in_ready=0, sde_out=1, sd_out=shift-register MSB.
  - Shift left each cycle for exactly DATABITS cycles, then return to IDLE and increment wcnt.
  - When wcnt reaches CMEMSIZE, wcnt wraps to 0 and load_done pulses in the cycle after the final shift edge.
  - Minimum word period: DATABITS+1 cycles.
- Ordering: the first word accepted lands at cmem address CMEMSIZE-1; the CMEMSIZE-th word lands at address 0. The host supplies words in descending address order.
- RD_SHIFT: sde_out=1, sd_out=sd_in (recirculate).
  - Capture register shifts in sd_in each cycle.
  - After DATABITS cycles, go to RD_HOLD.
- RD_HOLD: sde_out=0 (chain frozen); rd_valid=1; rd_data=captured word; rd_addr=CMEMSIZE-1-k for readback word k.
  - On rd_valid&rd_ready: if k==CMEMSIZE-1, pulse rd_done next cycle and go to IDLE; else go to RD_SHIFT.
  - rd_data and rd_addr stay stable while rd_ready=0.
- After a complete readback the chain has rotated CMEMSIZE*DATABITS bits, so cmem contents equal their pre-readback values.
- in_ready=0 and in_valid is ignored in every state except IDLE.
- No combinational path from any input to sde_out or rd_valid. sd_out is combinational from sd_in only in RD_SHIFT; this is not a loop because cmem's sd_out is registered.

Test Plan:
1. Load 0xA1, 0xB2, 0xC3, 0xD4 -> exactly 32 cycles with sde_out=1; cmem addr3=0xA1, addr2=0xB2, addr1=0xC3, addr0=0xD4; a single load_done pulse after the 4th word.
2. After test 1, pulse rd_start with rd_ready=1 -> rd_data/rd_addr sequence is (0xA1,3), (0xB2,2), (0xC3,1), (0xD4,0); one rd_done pulse; cmem contents unchanged.
3. Readback with rd_ready held low 5 cycles on word 2 -> sde_out=0 and rd_data=0xB2 stable throughout the stall; the remaining words are still correct.
4. In IDLE with wcnt=0, assert in_valid (0x5E) and rd_start in the same cycle -> load occurs, no readback, wcnt=1.
5. After 2 of 4 words loaded, pulse rd_start -> ignored (busy stays 0, rd_valid=0); then 2 more words give load_done.
6. Assert rst_n=0 after 3 shift cycles of a word -> immediately sde_out=0, busy=0; after release in_ready=1 and wcnt=0, and a full 4-word reload gives correct contents.

Source files
------------

// File: rtl/cmem_loader.sv
// Master end of the cmem coefficient scan chain: serial word loader and
// non-destructive recirculating readback with valid/ready handshakes.
module cmem_loader #(
  parameter int CMEMSIZE = 4,
  parameter int DATABITS = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATABITS-1:0]         in_data,
  input  logic                        rd_start,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [DATABITS-1:0]         rd_data,
  output logic [$clog2(CMEMSIZE)-1:0] rd_addr,
  output logic                        load_done,
  output logic                        rd_done,
  output logic                        busy,
  output logic                        sde_out,
  output logic                        sd_out,
  input  logic                        sd_in
);

  localparam int AW = $clog2(CMEMSIZE);
  localparam int BW = $clog2(DATABITS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(CMEMSIZE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATABITS - 1);
  localparam logic [AW-1:0] ZERO_A    = AW'(0);
  localparam logic [BW-1:0] ZERO_B    = BW'(0);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_SHIFT = 2'd1,
    RD_SHIFT   = 2'd2,
    RD_HOLD    = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [AW-1:0]       wcnt_r, wcnt_s;
  logic [AW-1:0]       rcnt_r, rcnt_s;
  logic [BW-1:0]       bcnt_r, bcnt_s;
  logic [DATABITS-1:0] shreg_r, shreg_s;
  logic [DATABITS-1:0] cap_r, cap_s;
  logic [AW-1:0]       addr_r, addr_s;
  logic                load_done_r, load_done_s;
  logic                rd_done_r, rd_done_s;

  // State, counters, shift/capture registers and done pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      wcnt_r      <= ZERO_A;
      rcnt_r      <= ZERO_A;
      bcnt_r      <= ZERO_B;
      shreg_r     <= {DATABITS{1'b0}};
      cap_r       <= {DATABITS{1'b0}};
      addr_r      <= ZERO_A;
      load_done_r <= 1'b0;
      rd_done_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      wcnt_r      <= wcnt_s;
      rcnt_r      <= rcnt_s;
      bcnt_r      <= bcnt_s;
      shreg_r     <= shreg_s;
      cap_r       <= cap_s;
      addr_r      <= addr_s;
      load_done_r <= load_done_s;
      rd_done_r   <= rd_done_s;
    end
  end

  // Next-state logic and state-decoded chain/handshake outputs
  always_comb begin
    state_s     = state_r;
    wcnt_s      = wcnt_r;
    rcnt_s      = rcnt_r;
    bcnt_s      = bcnt_r;
    shreg_s     = shreg_r;
    cap_s       = cap_r;
    addr_s      = addr_r;
    load_done_s = 1'b0;
    rd_done_s   = 1'b0;
    in_ready    = 1'b0;
    busy        = 1'b1;
    sde_out     = 1'b0;
    sd_out      = 1'b0;
    rd_valid    = 1'b0;

    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          shreg_s = in_data;
          bcnt_s  = ZERO_B;
          state_s = LOAD_SHIFT;
        end else if (rd_start && (wcnt_r == ZERO_A)) begin
          // Readback is refused while a partial load would be disturbed
          bcnt_s  = ZERO_B;
          rcnt_s  = ZERO_A;
          state_s = RD_SHIFT;
        end else begin
          state_s = IDLE;
        end
      end

      LOAD_SHIFT: begin
        sde_out = 1'b1;
        sd_out  = shreg_r[DATABITS-1];
        shreg_s = {shreg_r[DATABITS-2:0], 1'b0};
        if (bcnt_r == LAST_BIT) begin
          bcnt_s  = ZERO_B;
          state_s = IDLE;
          if (wcnt_r == LAST_ADDR) begin
            wcnt_s      = ZERO_A;
            load_done_s = 1'b1;
          end else begin
            wcnt_s = wcnt_r + 1'b1;
          end
        end else begin
          bcnt_s  = bcnt_r + 1'b1;
          state_s = LOAD_SHIFT;
        end
      end

      RD_SHIFT: begin
        // Chain output is fed straight back so a full pass restores cmem
        sde_out = 1'b1;
        sd_out  = sd_in;
        cap_s   = {cap_r[DATABITS-2:0], sd_in};
        if (bcnt_r == LAST_BIT) begin
          bcnt_s  = ZERO_B;
          addr_s  = LAST_ADDR - rcnt_r;
          state_s = RD_HOLD;
        end else begin
          bcnt_s  = bcnt_r + 1'b1;
          state_s = RD_SHIFT;
        end
      end

      RD_HOLD: begin
        rd_valid = 1'b1;
        if (rd_ready) begin
          if (rcnt_r == LAST_ADDR) begin
            rcnt_s    = ZERO_A;
            rd_done_s = 1'b1;
            state_s   = IDLE;
          end else begin
            rcnt_s  = rcnt_r + 1'b1;
            state_s = RD_SHIFT;
          end
        end else begin
          state_s = RD_HOLD;
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign rd_data   = cap_r;
  assign rd_addr   = addr_r;
  assign load_done = load_done_r;
  assign rd_done   = rd_done_r;

endmodule

// File: tb/tb_cmem_loader.sv
// Self-checking bench for cmem_loader: behavioural cmem chain, a transaction-level
// expectation model checked every cycle, and directed literal checks.
module tb_cmem_loader;

  logic       clk, rst_n;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic       rd_start, rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic [1:0] rd_addr;
  logic       load_done, rd_done, busy, sde_out, sd_out, sd_in;

  int checks   = 0;
  int failures = 0;

  cmem_loader #(.CMEMSIZE(4), .DATABITS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rd_start(rd_start), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_addr(rd_addr),
    .load_done(load_done), .rd_done(rd_done), .busy(busy),
    .sde_out(sde_out), .sd_out(sd_out), .sd_in(sd_in)
  );

  always #5 clk = ~clk;

  // Behavioural cmem chain: address a occupies chain[8a+7:8a], MSB registered out
  logic [31:0] chain = 32'h0;
  always @(posedge clk) begin
    if (sde_out) chain <= {chain[30:0], sd_out};
  end
  assign sd_in = chain[31];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expectation model state
  int         m_left = 0;
  bit         m_kind_rd = 1'b0;
  bit         m_hold = 1'b0;
  int         m_k = 0;
  int         m_loaded = 0;
  bit         m_ldp = 1'b0;
  bit         m_rdp = 1'b0;
  logic [7:0] m_word = 8'h0;
  logic [7:0] m_pend[4];
  logic [7:0] m_mem[4];

  int sde_cnt = 0, ld_cnt = 0, rd_cnt = 0, rdv_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sde_out)   sde_cnt++;
        if (load_done) ld_cnt++;
        if (rd_done)   rd_cnt++;
        if (rd_valid)  rdv_cnt++;
      end
    end
  end

  initial begin
    bit idle, ldp, rdp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_left = 0; m_hold = 1'b0; m_k = 0; m_loaded = 0; m_ldp = 1'b0; m_rdp = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sde", 32'(sde_out), 32'd0);
        chk("rst_sd", 32'(sd_out), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_done", 32'({load_done, rd_done}), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
      end else begin
        idle = (m_left == 0) && !m_hold;
        chk("in_ready", 32'(in_ready), 32'(idle));
        chk("busy", 32'(busy), 32'(!idle));
        chk("sde_out", 32'(sde_out), 32'(m_left > 0));
        chk("rd_valid", 32'(rd_valid), 32'(m_hold));
        chk("load_done", 32'(load_done), 32'(m_ldp));
        chk("rd_done", 32'(rd_done), 32'(m_rdp));
        if (m_left > 0 && !m_kind_rd) chk("sd_out_load", 32'(sd_out), 32'(m_word[m_left-1]));
        if (m_left > 0 && m_kind_rd)  chk("sd_out_recirc", 32'(sd_out), 32'(sd_in));
        if (m_hold) begin
          chk("rd_addr", 32'(rd_addr), 32'(3 - m_k));
          chk("rd_data", 32'(rd_data), 32'(m_mem[3 - m_k]));
        end
        ldp = 1'b0;
        rdp = 1'b0;
        if (idle) begin
          if (in_valid) begin
            m_word = in_data; m_left = 8; m_kind_rd = 1'b0;
          end else if (rd_start && m_loaded == 0) begin
            m_left = 8; m_kind_rd = 1'b1; m_k = 0;
          end
        end else if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin
            if (!m_kind_rd) begin
              m_pend[m_loaded] = m_word;
              m_loaded++;
              if (m_loaded == 4) begin
                for (int i = 0; i < 4; i++) m_mem[3 - i] = m_pend[i];
                m_loaded = 0;
                ldp = 1'b1;
              end
            end else begin
              m_hold = 1'b1;
            end
          end
        end else if (rd_ready) begin
          m_hold = 1'b0;
          if (m_k == 3) begin
            rdp = 1'b1; m_k = 0;
          end else begin
            m_k++; m_left = 8; m_kind_rd = 1'b1;
          end
        end
        m_ldp = ldp;
        m_rdp = rdp;
      end
    end
  end

  logic [7:0] got_data[4];
  logic [1:0] got_addr[4];

  task automatic send_word(input logic [7:0] w);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout: in_ready got 0 want 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic readback(input int stall_k, input logic [7:0] stall_val);
    int n;
    @(posedge clk); #1;
    rd_ready = 1'b1;
    rd_start = 1'b1;
    if (stall_k == 0) rd_ready = 1'b0;
    @(posedge clk); #1;
    rd_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      @(negedge clk);
      while (!rd_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (!rd_valid) begin
        checks++; failures++;
        $display("FAIL rd_timeout: rd_valid got 0 want 1 for word %0d", k);
        rd_ready = 1'b1;
        return;
      end
      got_data[k] = rd_data;
      got_addr[k] = rd_addr;
      if (k == stall_k) begin
        repeat (5) begin
          @(negedge clk);
          chk("stall_sde", 32'(sde_out), 32'd0);
          chk("stall_valid", 32'(rd_valid), 32'd1);
          chk("stall_data", 32'(rd_data), 32'(stall_val));
        end
        @(posedge clk); #1;
        rd_ready = 1'b1;
      end
      @(posedge clk); #1;
      if (k + 1 == stall_k) rd_ready = 1'b0;
    end
  endtask

  task automatic check_words(input string tag, input logic [31:0] exp);
    logic [31:0] e;
    e = exp;
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_data"}, 32'(got_data[k]), 32'(e[31 - 8*k -: 8]));
      chk({tag, "_addr"}, 32'(got_addr[k]), 32'(3 - k));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_sde, b_ld, b_rd, b_rdv;
    clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    rd_start = 1'b0; rd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Test 1: four-word load
    b_sde = sde_cnt; b_ld = ld_cnt;
    send_word(8'hA1); send_word(8'hB2); send_word(8'hC3); send_word(8'hD4);
    repeat (12) @(posedge clk); #1;
    chk("t1_sde_cycles", 32'(sde_cnt - b_sde), 32'd32);
    chk("t1_load_done_pulses", 32'(ld_cnt - b_ld), 32'd1);
    chk("t1_chain", chain, 32'hA1B2C3D4);

    // Test 2: full readback, rd_ready held high
    b_rd = rd_cnt;
    readback(-1, 8'h00);
    repeat (4) @(posedge clk); #1;
    check_words("t2", 32'hA1B2C3D4);
    chk("t2_rd_done_pulses", 32'(rd_cnt - b_rd), 32'd1);
    chk("t2_chain_restored", chain, 32'hA1B2C3D4);

    // Test 3: readback with word 2 stalled
    b_rd = rd_cnt;
    readback(1, 8'hB2);
    repeat (4) @(posedge clk); #1;
    check_words("t3", 32'hA1B2C3D4);
    chk("t3_rd_done_pulses", 32'(rd_cnt - b_rd), 32'd1);
    chk("t3_chain_restored", chain, 32'hA1B2C3D4);

    // Test 4: load wins over simultaneous rd_start
    b_rdv = rdv_cnt;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'h5E; rd_start = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; rd_start = 1'b0;
    repeat (12) @(posedge clk); #1;
    chk("t4_no_readback", 32'(rdv_cnt - b_rdv), 32'd0);
    chk("t4_chain_low", 32'(chain[7:0]), 32'h5E);

    // Test 5: rd_start ignored mid-sequence, then completion
    b_ld = ld_cnt;
    send_word(8'h11);
    repeat (10) @(posedge clk); #1;
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_rd_valid", 32'(rd_valid), 32'd0);
    end
    send_word(8'h22); send_word(8'h33);
    repeat (12) @(posedge clk); #1;
    chk("t5_load_done_pulses", 32'(ld_cnt - b_ld), 32'd1);
    chk("t5_chain", chain, 32'h5E112233);
    chk("t5_no_readback", 32'(rdv_cnt - b_rdv), 32'd0);

    // Test 6: reset in the middle of a word, then full reload
    send_word(8'h77);
    repeat (10) @(posedge clk);
    send_word(8'h88);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_sde_in_reset", 32'(sde_out), 32'd0);
    chk("t6_busy_in_reset", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_in_ready_after", 32'(in_ready), 32'd1);
    b_ld = ld_cnt;
    send_word(8'h3C); send_word(8'h5A); send_word(8'h96); send_word(8'hF0);
    repeat (12) @(posedge clk); #1;
    chk("t6_load_done_pulses", 32'(ld_cnt - b_ld), 32'd1);
    chk("t6_chain", chain, 32'h3C5A96F0);
    readback(-1, 8'h00);
    repeat (4) @(posedge clk); #1;
    check_words("t6", 32'h3C5A96F0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
